// File: rtl/muldiv_unit.sv
// Iterative RV-M multiply/divide engine.
// Multiply retires MUL_STEP multiplier bits per cycle into a 2*XLEN accumulator.
// Divide is restoring and produces one quotient bit per cycle. Both run on
// operand magnitudes. A single FIX cycle then restores the sign and selects the result.
// Divide-by-zero and signed overflow bypass iteration and go straight to DONE.
module muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result,
    output logic            busy
);

    localparam int N_M = XLEN / MUL_STEP;
    localparam int N_D = XLEN;
    localparam int CW  = $clog2(XLEN);

    localparam logic [CW-1:0]   CNT_MUL = CW'(N_M - 1);
    localparam logic [CW-1:0]   CNT_DIV = CW'(N_D - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    if ((XLEN < 8) || ((XLEN & (XLEN - 1)) != 0) ||
        !((MUL_STEP == 1) || (MUL_STEP == 2) || (MUL_STEP == 4)) ||
        ((XLEN % MUL_STEP) != 0)) begin : g_param_check
        $error("muldiv_unit: unsupported XLEN/MUL_STEP combination");
    end

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } state_e;

    // Architectural state
    state_e              state_q;
    op_e                 op_q;
    logic [XLEN-1:0]     a_q;        // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]   acc_q;      // {partial product, multiplier} or {remainder, dividend/quotient}
    logic [CW-1:0]       cnt_q;      // iterations remaining minus one
    logic                neg_q;      // the selected result must be negated in FIX
    logic                resp_valid_q;
    logic [XLEN-1:0]     resp_result_q;

    // Request decode
    op_e                 req_op_e;
    logic                rs1_signed;
    logic                rs2_signed;
    logic                s1;
    logic                s2;
    logic [XLEN-1:0]     mag1;
    logic [XLEN-1:0]     mag2;
    logic                req_neg;
    logic                div_by_zero;
    logic                div_ovf;
    logic                special;
    logic [XLEN-1:0]     special_result;

    // Datapath next values
    logic [MUL_STEP-1:0]      mul_digit;
    logic [XLEN+MUL_STEP-1:0] mul_pp;
    logic [XLEN+MUL_STEP-1:0] mul_sum;
    logic [2*XLEN-1:0]        mul_acc_d;
    logic [XLEN:0]            div_shift;
    logic [XLEN:0]            div_diff;
    logic [2*XLEN-1:0]        div_acc_d;
    logic [2*XLEN-1:0]        prod_fix;
    logic [XLEN-1:0]          quo_fix;
    logic [XLEN-1:0]          rem_fix;
    logic [XLEN-1:0]          fix_result;

    assign req_op_e = op_e'(req_op);

    // Classify the incoming request: operand signedness, magnitudes, result sign, special cases
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        rs1_signed     = 1'b0;
        rs2_signed     = 1'b0;
        special_result = '0;
        case (req_op_e)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                rs1_signed = 1'b1;
                rs2_signed = 1'b1;
            end
            OP_MULHSU: rs1_signed = 1'b1;
            default:   ;
        endcase

        s1   = rs1_signed & req_rs1[XLEN-1];
        s2   = rs2_signed & req_rs2[XLEN-1];
        mag1 = s1 ? -req_rs1 : req_rs1;
        mag2 = s2 ? -req_rs2 : req_rs2;

        // Remainder follows the dividend; everything else is the XOR of operand signs.
        req_neg = (req_op_e == OP_REM) ? s1 : (s1 ^ s2);

        div_by_zero = req_op[2] && (req_rs2 == '0);
        div_ovf     = ((req_op_e == OP_DIV) || (req_op_e == OP_REM)) &&
                      (req_rs1 == MIN_NEG) && (req_rs2 == '1);
        special     = div_by_zero || div_ovf;

        if (div_by_zero) begin
            special_result = req_op[1] ? req_rs1 : '1;
        end else if (div_ovf) begin
            special_result = req_op[1] ? '0 : req_rs1;
        end
    end

    // One multiply step, one restoring-divide step, and the sign fix / result select
    always_comb begin
        mul_digit = acc_q[MUL_STEP-1:0];
        mul_pp    = {{MUL_STEP{1'b0}}, a_q} * {{XLEN{1'b0}}, mul_digit};
        mul_sum   = {{MUL_STEP{1'b0}}, acc_q[2*XLEN-1:XLEN]} + mul_pp;
        mul_acc_d = {mul_sum, acc_q[XLEN-1:MUL_STEP]};

        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, a_q};
        if (!div_diff[XLEN]) begin
            div_acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            div_acc_d = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end

        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

        case (op_q)
            OP_MUL:                     fix_result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:            fix_result = quo_fix;
            default:                    fix_result = rem_fix;
        endcase
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and clears every register, datapath included, so a
        // reset taken mid-iteration leaves no stale operand or partial result behind.
        if (!rstn) begin
            state_q       <= IDLE;
            op_q          <= OP_MUL;
            a_q           <= '0;
            acc_q         <= '0;
            cnt_q         <= '0;
            neg_q         <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_result_q <= '0;
        end else if (flush) begin
            // NOTE: non-blocking assignments throughout: every register updates from the
            // pre-edge values, independent of statement order.
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q  <= req_op_e;
                        neg_q <= req_neg;
                        if (special) begin
                            resp_result_q <= special_result;
                            state_q       <= DONE;
                        end else if (req_op[2]) begin
                            a_q     <= mag2;
                            acc_q   <= {{XLEN{1'b0}}, mag1};
                            cnt_q   <= CNT_DIV;
                            state_q <= DIV;
                        end else begin
                            a_q     <= mag1;
                            acc_q   <= {{XLEN{1'b0}}, mag2};
                            cnt_q   <= CNT_MUL;
                            state_q <= MUL;
                        end
                    end
                end
                MUL: begin
                    acc_q <= mul_acc_d;
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DIV: begin
                    acc_q <= div_acc_d;
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                FIX: begin
                    resp_result_q <= fix_result;
                    state_q       <= DONE;
                end
                DONE: begin
                    if (resp_valid_q && resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end else begin
                        resp_valid_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a MUL_STEP=1 and a MUL_STEP=4 instance
// checked against an arithmetic reference model of the RV-M operations.
module tb_muldiv_unit;

    localparam int            XLEN     = 32;
    localparam int            MAX_WAIT = 100;
    localparam logic [31:0]   MIN_NEG  = 32'h8000_0000;
    localparam logic [31:0]   ALL_ONES = 32'hFFFF_FFFF;

    typedef struct packed {
        logic        use4;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [7:0]  lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic [2:0]  req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;

    logic        req_valid, req_ready, resp_valid, resp_ready, busy;
    logic [31:0] resp_result;
    logic        req_valid4, req_ready4, resp_valid4, resp_ready4, busy4;
    logic [31:0] resp_result4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN), .MUL_STEP(1)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .busy(busy)
    );

    muldiv_unit #(.XLEN(XLEN), .MUL_STEP(4)) dut4 (
        .clk(clk), .rstn(rstn), .flush(flush),
        .req_valid(req_valid4), .req_ready(req_ready4), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2),
        .resp_valid(resp_valid4), .resp_ready(resp_ready4),
        .resp_result(resp_result4), .busy(busy4)
    );

    // RV-M result computed with plain 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ua, ub, q;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = '0;
        r  = '0;
        case (op)
            3'd0: begin p = sa * sb; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = ALL_ONES;
                else if (a == MIN_NEG && b == ALL_ONES) r = a;
                else begin q = sa / sb; p = q; r = p[31:0]; end
            end
            3'd5: r = (b == 0) ? ALL_ONES : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == MIN_NEG && b == ALL_ONES) r = '0;
                else begin q = sa % sb; p = q; r = p[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Edges from accept to resp_valid: 1 for special cases, N+2 otherwise
    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input bit use4);
        if (op[2] && (b == 0 || ((op == 3'd4 || op == 3'd6) && a == MIN_NEG && b == ALL_ONES)))
            return 1;
        if (op[2]) return XLEN + 2;
        return (use4 ? XLEN / 4 : XLEN) + 2;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [5];
        corners = '{32'h0, 32'h1, ALL_ONES, MIN_NEG, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    // Issue one request, wait (bounded) for the response, then take it
    task automatic run_op(input bit use4, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res, output int lat);
        @(negedge clk);
        req_op  = op;
        req_rs1 = a;
        req_rs2 = b;
        if (use4) req_valid4 = 1'b1; else req_valid = 1'b1;
        @(negedge clk);
        req_valid  = 1'b0;
        req_valid4 = 1'b0;
        lat = 0;
        while (((use4 ? resp_valid4 : resp_valid) !== 1'b1) && lat < MAX_WAIT) begin
            @(negedge clk);
            lat++;
        end
        res = use4 ? resp_result4 : resp_result;
        if (use4) resp_ready4 = 1'b1; else resp_ready = 1'b1;
        @(negedge clk);
        resp_ready  = 1'b0;
        resp_ready4 = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (resp_valid !== 1'b0 || resp_result !== 32'h0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_step1: valid=%b result=%h ready=%b busy=%b, required 0/00000000/1/0",
                     resp_valid, resp_result, req_ready, busy);
        end
        n_checks++;
        if (resp_valid4 !== 1'b0 || resp_result4 !== 32'h0 || req_ready4 !== 1'b1 || busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_step4: valid=%b result=%h ready=%b busy=%b, required 0/00000000/1/0",
                     resp_valid4, resp_result4, req_ready4, busy4);
        end
    endtask

    task automatic test_multiply();
        vec_t        v [6];
        logic [31:0] r;
        int          l;
        v[0] = '{1'b0, 3'd0, MIN_NEG,  MIN_NEG,  32'h0000_0000, 8'd34};
        v[1] = '{1'b0, 3'd1, MIN_NEG,  MIN_NEG,  32'h4000_0000, 8'd34};
        v[2] = '{1'b0, 3'd3, ALL_ONES, ALL_ONES, 32'hFFFF_FFFE, 8'd34};
        v[3] = '{1'b0, 3'd2, ALL_ONES, ALL_ONES, 32'hFFFF_FFFF, 8'd34};
        v[4] = '{1'b1, 3'd2, ALL_ONES, ALL_ONES, 32'hFFFF_FFFF, 8'd10};
        v[5] = '{1'b1, 3'd1, MIN_NEG,  MIN_NEG,  32'h4000_0000, 8'd10};
        foreach (v[i]) begin
            run_op(v[i].use4, v[i].op, v[i].a, v[i].b, r, l);
            n_checks++;
            if (r !== v[i].res) begin
                n_fail++;
                $display("FAIL mul_result[%0d] op=%0d: got %h, required %h", i, v[i].op, r, v[i].res);
            end
            n_checks++;
            if (l != int'(v[i].lat)) begin
                n_fail++;
                $display("FAIL mul_latency[%0d] op=%0d: got %0d, required %0d", i, v[i].op, l, v[i].lat);
            end
        end
    endtask

    task automatic test_special();
        vec_t        v [7];
        logic [31:0] r;
        int          l;
        v[0] = '{1'b0, 3'd4, 32'd7,   32'd0,    ALL_ONES,      8'd1};
        v[1] = '{1'b0, 3'd6, 32'd7,   32'd0,    32'h0000_0007, 8'd1};
        v[2] = '{1'b0, 3'd5, 32'd5,   32'd0,    ALL_ONES,      8'd1};
        v[3] = '{1'b0, 3'd7, 32'd5,   32'd0,    32'h0000_0005, 8'd1};
        v[4] = '{1'b0, 3'd4, MIN_NEG, ALL_ONES, MIN_NEG,       8'd1};
        v[5] = '{1'b0, 3'd6, MIN_NEG, ALL_ONES, 32'h0000_0000, 8'd1};
        v[6] = '{1'b1, 3'd4, MIN_NEG, ALL_ONES, MIN_NEG,       8'd1};
        foreach (v[i]) begin
            run_op(v[i].use4, v[i].op, v[i].a, v[i].b, r, l);
            n_checks++;
            if (r !== v[i].res) begin
                n_fail++;
                $display("FAIL special_result[%0d] op=%0d: got %h, required %h", i, v[i].op, r, v[i].res);
            end
            n_checks++;
            if (l != int'(v[i].lat)) begin
                n_fail++;
                $display("FAIL special_latency[%0d] op=%0d: got %0d, required %0d", i, v[i].op, l, v[i].lat);
            end
        end
    endtask

    task automatic test_divide();
        vec_t        v [5];
        logic [31:0] r;
        int          l;
        v[0] = '{1'b0, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 8'd34};
        v[1] = '{1'b0, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 8'd34};
        v[2] = '{1'b0, 3'd5, 32'd100,       32'd7, 32'd14,        8'd34};
        v[3] = '{1'b0, 3'd7, 32'd100,       32'd7, 32'd2,         8'd34};
        v[4] = '{1'b1, 3'd4, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 8'd34};
        foreach (v[i]) begin
            run_op(v[i].use4, v[i].op, v[i].a, v[i].b, r, l);
            n_checks++;
            if (r !== v[i].res) begin
                n_fail++;
                $display("FAIL div_result[%0d] op=%0d: got %h, required %h", i, v[i].op, r, v[i].res);
            end
            n_checks++;
            if (l != int'(v[i].lat)) begin
                n_fail++;
                $display("FAIL div_latency[%0d] op=%0d: got %0d, required %0d", i, v[i].op, l, v[i].lat);
            end
        end
    endtask

    task automatic test_hold();
        int lat;
        int xfers;
        @(negedge clk);
        req_op = 3'd5; req_rs1 = 32'd100; req_rs2 = 32'd7; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < MAX_WAIT) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_timeout: resp_valid=%b after %0d cycles, required 1", resp_valid, lat);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (resp_result !== 32'd14 || req_ready !== 1'b0 || resp_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_stable[%0d]: result=%h ready=%b valid=%b, required 0000000e/0/1",
                         i, resp_result, req_ready, resp_valid);
            end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        xfers = 0;
        for (int i = 0; i < 3; i++) begin
            if (resp_valid === 1'b1) xfers++;
            @(negedge clk);
        end
        resp_ready = 1'b0;
        n_checks++;
        if (xfers != 1 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_transfer: xfers=%0d valid=%b ready=%b, required 1/0/1",
                     xfers, resp_valid, req_ready);
        end
    endtask

    task automatic test_flush();
        int          seen;
        logic [31:0] r;
        int          l;
        @(negedge clk);
        req_op = 3'd4; req_rs1 = 32'd1000; req_rs2 = 32'd3; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_idle: busy=%b valid=%b ready=%b, required 0/0/1", busy, resp_valid, req_ready);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL flush_no_resp: resp_valid high %0d cycles, required 0", seen);
        end
        // A request offered together with flush in IDLE is dropped.
        req_op = 3'd0; req_rs1 = 32'd5; req_rs2 = 32'd6; req_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_vs_req: busy=%b ready=%b, required 0/1", busy, req_ready);
        end
        run_op(1'b0, 3'd0, 32'd3, 32'd4, r, l);
        n_checks++;
        if (r !== 32'd12 || l != 34) begin
            n_fail++;
            $display("FAIL flush_next_mul: result=%h lat=%0d, required 0000000c/34", r, l);
        end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        req_op = 3'd0; req_rs1 = 32'd123; req_rs2 = 32'd456; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        n_checks++;
        if (resp_valid !== 1'b0 || resp_result !== 32'h0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_mul: valid=%b result=%h ready=%b busy=%b, required 0/00000000/1/0",
                     resp_valid, resp_result, req_ready, busy);
        end
        repeat (40) @(negedge clk);
        n_checks++;
        if (resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_no_resp: resp_valid=%b, required 0", resp_valid);
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, r, exp_r;
        bit          use4;
        int          l, exp_l;
        for (int i = 0; i < 48; i++) begin
            use4  = (i % 3 == 0);
            op    = 3'($urandom_range(0, 7));
            a     = pick_operand();
            b     = pick_operand();
            exp_r = ref_model(op, a, b);
            exp_l = exp_lat(op, a, b, use4);
            run_op(use4, op, a, b, r, l);
            n_checks++;
            if (r !== exp_r) begin
                n_fail++;
                $display("FAIL rand_result[%0d] step4=%0d op=%0d a=%h b=%h: got %h, required %h",
                         i, use4, op, a, b, r, exp_r);
            end
            n_checks++;
            if (l != exp_l) begin
                n_fail++;
                $display("FAIL rand_latency[%0d] step4=%0d op=%0d: got %0d, required %0d",
                         i, use4, op, l, exp_l);
            end
        end
    endtask

    initial begin
        rstn        = 1'b0;
        flush       = 1'b0;
        req_valid   = 1'b0;
        req_valid4  = 1'b0;
        resp_ready  = 1'b0;
        resp_ready4 = 1'b0;
        req_op      = 3'd0;
        req_rs1     = '0;
        req_rs2     = '0;

        test_reset();
        test_multiply();
        test_special();
        test_divide();
        test_hold();
        test_flush();
        test_reset_mid_op();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
